// File: rtl/vending_sequencer.sv
// Vending machine transaction sequencer: product select, coin accumulation,
// dispense with change, refund on cancel/timeout, plus a free-running LED blink.
module vending_sequencer #(
    parameter int unsigned P_CHILD     = 10,
    parameter int unsigned P_MEN       = 15,
    parameter int unsigned P_WOMEN     = 20,
    parameter int unsigned STOCK_INIT  = 3,
    parameter int unsigned BLINK_HALF  = 4,
    parameter int unsigned DISP_CYCLES = 8,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       sw_child,
    input  logic       sw_men,
    input  logic       sw_women,
    input  logic       cancel,
    input  logic [1:0] coin_in,
    output logic [1:0] state,
    output logic       blink,
    output logic       en_child,
    output logic       en_men,
    output logic       en_women,
    output logic [5:0] credit,
    output logic       vend_child,
    output logic       vend_men,
    output logic       vend_women,
    output logic [5:0] change,
    output logic       change_valid,
    output logic       coin_reject
);

    localparam int unsigned CW = 6;
    localparam int unsigned SW = 4;
    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned DW = $clog2(DISP_CYCLES + 1);
    localparam int unsigned BW = $clog2(BLINK_HALF + 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'b00,
        S_SELECT   = 2'b01,
        S_PAY      = 2'b10,
        S_DISPENSE = 2'b11
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          credit_q, credit_d;
    logic [CW-1:0]          change_q, change_d;
    logic                   change_valid_q, change_valid_d;
    logic                   coin_reject_q, coin_reject_d;
    logic [2:0]             vend_q, vend_d;
    logic [2:0]             prod_q, prod_d;
    logic [2:0]             sw_q;
    logic [2:0][SW-1:0]     stock_q, stock_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic [DW-1:0]          disp_q, disp_d;
    logic [BW-1:0]          blink_cnt_q, blink_cnt_d;
    logic                   blink_q, blink_d;

    logic [2:0]             sw;
    logic [2:0]             avail;
    logic [CW-1:0]          coin_val;
    logic [CW:0]            sum_raw;
    logic [CW-1:0]          credit_sum;
    logic [CW-1:0]          price;
    logic                   sel_ok;
    logic                   activity;
    logic                   expired;

    assign sw = {sw_women, sw_men, sw_child};

    // Product availability is combinational from stock so it tracks every decrement.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            avail[i] = (stock_q[i] != '0);
        end
    end

    always_comb begin
        case (coin_in)
            2'b01:   coin_val = CW'(1);
            2'b10:   coin_val = CW'(5);
            2'b11:   coin_val = CW'(10);
            default: coin_val = '0;
        endcase
    end

    // Credit accumulation saturates at the top of the credit range.
    assign sum_raw    = {1'b0, credit_q} + {1'b0, coin_val};
    assign credit_sum = sum_raw[CW] ? '1 : sum_raw[CW-1:0];

    always_comb begin
        case (prod_q)
            3'b001:  price = CW'(P_CHILD);
            3'b010:  price = CW'(P_MEN);
            default: price = CW'(P_WOMEN);
        endcase
    end

    assign sel_ok   = $onehot(sw) && ((sw & avail) != 3'b000);
    assign activity = (coin_in != 2'b00) || (sw != sw_q);
    assign expired  = !activity && (tmo_q == TW'(TIMEOUT - 1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        change_d       = '0;
        change_valid_d = 1'b0;
        vend_d         = 3'b000;
        prod_d         = prod_q;
        stock_d        = stock_q;
        disp_d         = '0;
        coin_reject_d  = (coin_in != 2'b00) && (state_q != S_PAY);
        blink_d        = blink_q;
        blink_cnt_d    = blink_cnt_q + BW'(1);

        if (blink_cnt_q == BW'(BLINK_HALF - 1)) begin
            blink_cnt_d = '0;
            blink_d     = ~blink_q;
        end

        case (state_q)
            S_IDLE: begin
                credit_d = '0;
                if (start) begin
                    state_d = S_SELECT;
                end
            end
            S_SELECT: begin
                if (cancel || expired) begin
                    state_d = S_IDLE;
                end else if (sel_ok) begin
                    prod_d  = sw;
                    state_d = S_PAY;
                end
            end
            S_PAY: begin
                // Cancel/timeout wins over price-reached; same-cycle coin is refunded too.
                if (cancel || expired) begin
                    state_d        = S_IDLE;
                    change_valid_d = 1'b1;
                    change_d       = credit_sum;
                    credit_d       = '0;
                end else begin
                    credit_d = credit_sum;
                    if (credit_sum >= price) begin
                        state_d = S_DISPENSE;
                    end
                end
            end
            S_DISPENSE: begin
                disp_d = disp_q + DW'(1);
                if (disp_q == '0) begin
                    vend_d         = prod_q;
                    change_valid_d = 1'b1;
                    change_d       = credit_q - price;
                    credit_d       = '0;
                    for (int i = 0; i < 3; i++) begin
                        if (prod_q[i] && (stock_q[i] != '0)) begin
                            stock_d[i] = stock_q[i] - SW'(1);
                        end
                    end
                end
                if (disp_q == DW'(DISP_CYCLES - 1)) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if ((state_d != state_q) || activity) begin
            tmo_d = '0;
        end else if ((state_q == S_SELECT) || (state_q == S_PAY)) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            change_q       <= '0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            vend_q         <= 3'b000;
            prod_q         <= 3'b000;
            sw_q           <= 3'b000;
            stock_q        <= {3{SW'(STOCK_INIT)}};
            tmo_q          <= '0;
            disp_q         <= '0;
            blink_cnt_q    <= '0;
            blink_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            change_q       <= change_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            vend_q         <= vend_d;
            prod_q         <= prod_d;
            sw_q           <= sw;
            stock_q        <= stock_d;
            tmo_q          <= tmo_d;
            disp_q         <= disp_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_q        <= blink_d;
        end
    end

    assign state        = state_q;
    assign blink        = blink_q;
    assign en_child     = avail[0];
    assign en_men       = avail[1];
    assign en_women     = avail[2];
    assign credit       = credit_q;
    assign vend_child   = vend_q[0];
    assign vend_men     = vend_q[1];
    assign vend_women   = vend_q[2];
    assign change       = change_q;
    assign change_valid = change_valid_q;
    assign coin_reject  = coin_reject_q;

endmodule

// File: tb/tb_vending_sequencer.sv
// Bench for vending_sequencer: directed purchase/refund/timeout/reset scenarios,
// then random traffic, all checked every cycle against a transaction-level model.
module tb_vending_sequencer;

    localparam int unsigned P_CHILD     = 10;
    localparam int unsigned P_MEN       = 15;
    localparam int unsigned P_WOMEN     = 20;
    localparam int unsigned STOCK_INIT  = 3;
    localparam int unsigned BLINK_HALF  = 4;
    localparam int unsigned DISP_CYCLES = 8;
    localparam int unsigned TIMEOUT     = 64;

    localparam int PH_IDLE = 0;
    localparam int PH_SEL  = 1;
    localparam int PH_PAY  = 2;
    localparam int PH_DISP = 3;

    logic       clk = 1'b0;
    logic       rst_n, start, sw_child, sw_men, sw_women, cancel;
    logic [1:0] coin_in;
    logic [1:0] state;
    logic       blink, en_child, en_men, en_women;
    logic [5:0] credit, change;
    logic       vend_child, vend_men, vend_women, change_valid, coin_reject;

    always #5 clk = ~clk;

    vending_sequencer #(
        .P_CHILD(P_CHILD), .P_MEN(P_MEN), .P_WOMEN(P_WOMEN),
        .STOCK_INIT(STOCK_INIT), .BLINK_HALF(BLINK_HALF),
        .DISP_CYCLES(DISP_CYCLES), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .sw_child(sw_child), .sw_men(sw_men), .sw_women(sw_women),
        .cancel(cancel), .coin_in(coin_in), .state(state), .blink(blink),
        .en_child(en_child), .en_men(en_men), .en_women(en_women),
        .credit(credit), .vend_child(vend_child), .vend_men(vend_men),
        .vend_women(vend_women), .change(change), .change_valid(change_valid),
        .coin_reject(coin_reject)
    );

    int tests = 0;
    int fails = 0;

    int coin_tab  [4] = '{0, 1, 5, 10};
    int price_tab [3] = '{P_CHILD, P_MEN, P_WOMEN};

    // Reference model: transaction phase, wallet, inventory and per-cycle strobes.
    int       m_phase, m_credit, m_prod, m_age, m_disp, m_cycles, m_change;
    int       m_stock [3];
    bit       m_cv, m_rej;
    bit [2:0] m_vend, m_prev_sw;

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step();
        int       cv, sum, nxt, idx;
        bit [2:0] sw;
        bit       active, expired;
        sw       = {sw_women, sw_men, sw_child};
        cv       = coin_tab[coin_in];
        m_cv     = 1'b0;
        m_rej    = 1'b0;
        m_vend   = 3'b000;
        m_change = 0;
        if (!rst_n) begin
            m_phase = PH_IDLE; m_credit = 0; m_prod = 0; m_age = 0;
            m_disp = 0; m_cycles = 0; m_prev_sw = 3'b000;
            foreach (m_stock[i]) m_stock[i] = STOCK_INIT;
            return;
        end
        m_cycles++;
        active    = (cv != 0) || (sw != m_prev_sw);
        expired   = !active && (m_age == int'(TIMEOUT) - 1);
        m_prev_sw = sw;
        m_rej     = (cv != 0) && (m_phase != PH_PAY);
        nxt       = m_phase;
        case (m_phase)
            PH_IDLE: if (start) nxt = PH_SEL;
            PH_SEL: begin
                if (cancel || expired) nxt = PH_IDLE;
                else if ($countones(sw) == 1) begin
                    idx = sw[0] ? 0 : (sw[1] ? 1 : 2);
                    if (m_stock[idx] > 0) begin
                        m_prod = idx;
                        nxt    = PH_PAY;
                    end
                end
            end
            PH_PAY: begin
                sum = m_credit + cv;
                if (sum > 63) sum = 63;
                if (cancel || expired) begin
                    nxt = PH_IDLE; m_cv = 1'b1; m_change = sum; m_credit = 0;
                end else begin
                    m_credit = sum;
                    if (sum >= price_tab[m_prod]) nxt = PH_DISP;
                end
            end
            default: begin
                if (m_disp == 0) begin
                    m_vend[m_prod] = 1'b1;
                    m_stock[m_prod]--;
                    m_cv     = 1'b1;
                    m_change = m_credit - price_tab[m_prod];
                    m_credit = 0;
                end
                m_disp++;
                if (m_disp == int'(DISP_CYCLES)) nxt = PH_IDLE;
            end
        endcase
        if (nxt != m_phase) begin
            m_age  = 0;
            m_disp = 0;
        end else if (active) m_age = 0;
        else m_age++;
        m_phase = nxt;
    endtask

    task automatic compare_all();
        chk("state", int'(state), m_phase);
        chk("blink", int'(blink), int'((m_cycles / BLINK_HALF) % 2));
        chk("credit", int'(credit), m_credit);
        chk("change_valid", int'(change_valid), int'(m_cv));
        if (m_cv) chk("change", int'(change), m_change);
        chk("vend_child", int'(vend_child), int'(m_vend[0]));
        chk("vend_men", int'(vend_men), int'(m_vend[1]));
        chk("vend_women", int'(vend_women), int'(m_vend[2]));
        chk("coin_reject", int'(coin_reject), int'(m_rej));
        chk("en_child", int'(en_child), int'(m_stock[0] != 0));
        chk("en_men", int'(en_men), int'(m_stock[1] != 0));
        chk("en_women", int'(en_women), int'(m_stock[2] != 0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic set_sw(input bit [2:0] v);
        {sw_women, sw_men, sw_child} = v;
    endtask

    task automatic buy_child_exact();
        start = 1'b1; tick(); start = 1'b0;
        set_sw(3'b001); tick(); set_sw(3'b000);
        coin_in = 2'b11; tick(); coin_in = 2'b00;
        repeat (DISP_CYCLES) tick();
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; coin_in = 2'b00;
        set_sw(3'b000);
        tick();
        chk("reset_state", int'(state), 0);
        chk("reset_credit", int'(credit), 0);
        chk("reset_blink", int'(blink), 0);
        rst_n = 1'b1;

        // Men purchase with exact change.
        start = 1'b1; tick(); start = 1'b0;
        chk("men_select", int'(state), 1);
        set_sw(3'b010); tick(); set_sw(3'b000);
        chk("men_pay", int'(state), 2);
        coin_in = 2'b11; tick();
        coin_in = 2'b10; tick(); coin_in = 2'b00;
        chk("men_disp_state", int'(state), 3);
        chk("men_credit", int'(credit), 15);
        tick();
        chk("men_vend", int'(vend_men), 1);
        chk("men_cv", int'(change_valid), 1);
        chk("men_change", int'(change), 0);
        repeat (DISP_CYCLES - 2) tick();
        chk("men_still_disp", int'(state), 3);
        tick();
        chk("men_back_idle", int'(state), 0);

        // Child purchase with 5 units change.
        start = 1'b1; tick(); start = 1'b0;
        set_sw(3'b001); tick(); set_sw(3'b000);
        coin_in = 2'b10; tick();
        coin_in = 2'b11; tick(); coin_in = 2'b00;
        chk("child_credit", int'(credit), 15);
        tick();
        chk("child_change", int'(change), 5);
        chk("child_vend", int'(vend_child), 1);
        repeat (DISP_CYCLES - 1) tick();

        // Exhaust child stock; out-of-stock selection holds SELECT.
        buy_child_exact();
        buy_child_exact();
        chk("child_empty", int'(en_child), 0);
        start = 1'b1; tick(); start = 1'b0;
        set_sw(3'b001); tick(); tick();
        chk("child_oos_hold", int'(state), 1);
        set_sw(3'b000); cancel = 1'b1; tick(); cancel = 1'b0;
        chk("sel_cancel_idle", int'(state), 0);
        chk("sel_cancel_no_cv", int'(change_valid), 0);

        // Cancel in PAY together with a coin refunds both.
        start = 1'b1; tick(); start = 1'b0;
        set_sw(3'b010); tick(); set_sw(3'b000);
        coin_in = 2'b10; tick();
        chk("pay_credit5", int'(credit), 5);
        coin_in = 2'b11; cancel = 1'b1; tick(); coin_in = 2'b00; cancel = 1'b0;
        chk("cancel_idle", int'(state), 0);
        chk("cancel_change", int'(change), 15);
        chk("cancel_cv", int'(change_valid), 1);
        chk("cancel_no_vend", int'(vend_men), 0);

        // SELECT timeout, then coin rejected in IDLE.
        start = 1'b1; tick(); start = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("timeout_pending", int'(state), 1);
        tick();
        chk("timeout_idle", int'(state), 0);
        coin_in = 2'b11; tick(); coin_in = 2'b00;
        chk("idle_reject", int'(coin_reject), 1);
        chk("idle_credit", int'(credit), 0);

        // Reset on the first DISPENSE cycle suppresses the vend and refund.
        start = 1'b1; tick(); start = 1'b0;
        set_sw(3'b100); tick(); set_sw(3'b000);
        coin_in = 2'b11; tick(); tick(); coin_in = 2'b00;
        chk("women_disp", int'(state), 3);
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rst_state", int'(state), 0);
        chk("rst_no_vend", int'(vend_women), 0);
        chk("rst_no_cv", int'(change_valid), 0);
        chk("rst_stock_child", int'(en_child), 1);
        tick();
        chk("rst_quiet_cv", int'(change_valid), 0);

        // Random traffic with periodic quiet windows to reach the timeout.
        for (int i = 0; i < 3000; i++) begin
            if ((i % 600) >= 520) begin
                rst_n = 1'b1; start = 1'b0; cancel = 1'b0; coin_in = 2'b00;
                if ((i % 600) == 520) start = 1'b1;
            end else begin
                rst_n  = ($urandom_range(0, 499) != 0);
                start  = ($urandom_range(0, 3) == 0);
                cancel = ($urandom_range(0, 39) == 0);
                coin_in = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                if ($urandom_range(0, 7) == 0) set_sw(3'($urandom_range(0, 7)));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
